// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared state type, derived refill sizes and parameter legality for the icache set
package icache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   function automatic int beats(input int b, input int fill_w);
      return (8 * b) / fill_w;
   endfunction

   // Byte-offset bits covered by one refill beat.
   function automatic int lane_bits(input int fill_w);
      return $clog2(fill_w / 8);
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit cfg_legal(input int b, input int tag_bits, input int e, input int fill_w);
      return is_pow2(b) && (b >= 8) && is_pow2(e) && (e >= 2) && (tag_bits >= 1) &&
             ((fill_w == 32) || (fill_w == 64) || (fill_w == 128)) && (fill_w <= 8 * b);
   endfunction

endpackage

// File: rtl/instr_cache_set_refill_if.sv
// rtl/instr_cache_set_refill_if.sv - lookup and L2 refill port bundle of one cache set
interface instr_cache_set_refill_if #(
   parameter int B        = 64,
   parameter int TAG_BITS = 20,
   parameter int FILL_W   = 64
);
   localparam int OFF_W = $clog2(B);

   logic                set_active_i;
   logic [TAG_BITS-1:0] tag_i;
   logic [OFF_W-1:0]    block_i;
   logic                flush_i;
   logic                fill_valid_i;
   logic [FILL_W-1:0]   fill_data_i;
   logic                fill_ready_o;
   logic                hit_o;
   logic                miss_o;
   logic                busy_o;
   logic                fill_done_o;
   logic [31:0]         data_o;

   modport master (
      output set_active_i, tag_i, block_i, flush_i, fill_valid_i, fill_data_i,
      input  fill_ready_o, hit_o, miss_o, busy_o, fill_done_o, data_o
   );

   modport slave (
      input  set_active_i, tag_i, block_i, flush_i, fill_valid_i, fill_data_i,
      output fill_ready_o, hit_o, miss_o, busy_o, fill_done_o, data_o
   );

endinterface

// File: rtl/icache_lru_age.sv
// rtl/icache_lru_age.sv - per-way age vector of one set; age 0 is most recently used
module icache_lru_age #(
   parameter  int E  = 4,
   localparam int AW = $clog2(E)
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 flush_i,
   input  logic                 upd_i,
   input  logic [AW-1:0]        upd_way_i,
   input  logic [AW-1:0]        ref_age_i,
   input  logic [E-1:0]         valid_i,
   output logic [E-1:0][AW-1:0] ages_o
);

   logic [E-1:0][AW-1:0] ages_q;

   // Ways younger than the reference age shift back by one so ages stay a permutation.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         ages_q <= '0;
      end else if (flush_i) begin
         ages_q <= '0;
      end else if (upd_i) begin
         for (int w = 0; w < E; w++) begin
            if (AW'(w) == upd_way_i) begin
               ages_q[w] <= '0;
            end else if (valid_i[w] && (ages_q[w] < ref_age_i)) begin
               ages_q[w] <= ages_q[w] + AW'(1);
            end
         end
      end
   end

   assign ages_o = ages_q;

endmodule

// File: rtl/instr_cache_set_refill.sv
// rtl/instr_cache_set_refill.sv - E-way instruction-cache set with multi-beat refill, flush and abort
module instr_cache_set_refill
   import icache_pkg::*;
#(
   parameter int B        = 64,
   parameter int TAG_BITS = 20,
   parameter int E        = 4,
   parameter int FILL_W   = 64
) (
   input logic                    clk_i,
   input logic                    reset_ni,
   instr_cache_set_refill_if.slave bus
);

   localparam int BEATS   = beats(B, FILL_W);
   localparam int LB      = lane_bits(FILL_W);
   localparam int OFF_W   = $clog2(B);
   localparam int WAY_W   = $clog2(E);
   localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ENTRIES = E * BEATS;
   localparam int IDX_W   = $clog2(ENTRIES);
   localparam int LANES   = FILL_W / 32;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   if (!cfg_legal(B, TAG_BITS, E, FILL_W)) begin : g_bad_cfg
      $error("instr_cache_set_refill: illegal B/TAG_BITS/E/FILL_W combination");
   end

   fill_state_t          state_q, state_d;
   logic [E-1:0]         valid_q;
   logic [TAG_BITS-1:0]  tag_q [E];
   logic [WAY_W-1:0]     victim_q, old_age_q;
   logic [TAG_BITS-1:0]  tag_cap_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 done_q;
   logic [FILL_W-1:0]    mem [ENTRIES];

   logic [E-1:0]         way_hit;
   logic                 hit_any, miss;
   logic [WAY_W-1:0]     hit_way, vic_way;
   logic                 vic_free;
   logic                 alloc, beat_fire, commit;
   logic [E-1:0][WAY_W-1:0] ages;
   logic [OFF_W-1:0]     beat_off, word_off;
   logic [IDX_W-1:0]     rd_idx, wr_idx;
   logic [FILL_W-1:0]    rd_entry;
   logic [31:0]          rd_word;
   int                   lane;

   // Lookup only in IDLE, so an in-flight refill can never report a hit.
   always_comb begin
      way_hit = '0;
      for (int w = 0; w < E; w++) begin
         way_hit[w] = (state_q == IDLE) && bus.set_active_i && valid_q[w] &&
                      (tag_q[w] == bus.tag_i);
      end
   end

   assign hit_any = |way_hit;
   assign miss    = bus.set_active_i && !hit_any && (state_q == IDLE);

   always_comb begin
      hit_way = '0;
      for (int w = E - 1; w >= 0; w--) begin
         if (way_hit[w]) hit_way = WAY_W'(w);
      end
   end

   // Victim: lowest invalid way, otherwise the oldest valid way.
   always_comb begin
      vic_way  = '0;
      vic_free = 1'b0;
      for (int w = E - 1; w >= 0; w--) begin
         if (!valid_q[w]) begin
            vic_way  = WAY_W'(w);
            vic_free = 1'b1;
         end
      end
      if (!vic_free) begin
         for (int w = 0; w < E; w++) begin
            if (ages[w] == WAY_W'(E - 1)) vic_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      alloc     = 1'b0;
      beat_fire = 1'b0;
      commit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (miss && !bus.flush_i) begin
               state_d = FILL;
               alloc   = 1'b1;
            end
         end
         FILL: begin
            if (bus.flush_i) begin
               state_d = IDLE;
            end else if (bus.fill_valid_i) begin
               beat_fire = 1'b1;
               if (cnt_q == LAST_BEAT) begin
                  commit  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (bus.flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= IDLE;
         valid_q   <= '0;
         cnt_q     <= '0;
         victim_q  <= '0;
         old_age_q <= '0;
         tag_cap_q <= '0;
         done_q    <= 1'b0;
         for (int w = 0; w < E; w++) tag_q[w] <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= commit;
         if (bus.flush_i) begin
            valid_q <= '0;
            cnt_q   <= '0;
         end else if (alloc) begin
            // The victim is invalidated now so an aborted refill leaves no stale hit.
            victim_q          <= vic_way;
            tag_cap_q         <= bus.tag_i;
            old_age_q         <= vic_free ? WAY_W'(E - 1) : ages[vic_way];
            valid_q[vic_way]  <= 1'b0;
            cnt_q             <= '0;
         end else if (beat_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (commit) begin
               valid_q[victim_q] <= 1'b1;
               tag_q[victim_q]   <= tag_cap_q;
               cnt_q             <= '0;
            end
         end
      end
   end

   assign wr_idx = IDX_W'(int'(victim_q) * BEATS + int'(cnt_q));

   always_ff @(posedge clk_i) begin
      if (beat_fire) mem[wr_idx] <= bus.fill_data_i;
   end

   icache_lru_age #(
      .E (E)
   ) u_lru (
      .clk_i     (clk_i),
      .reset_ni  (reset_ni),
      .flush_i   (bus.flush_i),
      .upd_i     ((hit_any && !bus.flush_i) || commit),
      .upd_way_i (commit ? victim_q : hit_way),
      .ref_age_i (commit ? old_age_q : ages[hit_way]),
      .valid_i   (valid_q),
      .ages_o    (ages)
   );

   assign beat_off = bus.block_i >> LB;
   assign word_off = bus.block_i >> 2;
   assign rd_idx   = IDX_W'(int'(hit_way) * BEATS + int'(beat_off));
   assign rd_entry = mem[rd_idx];
   assign lane     = int'(word_off) % LANES;
   assign rd_word  = 32'(rd_entry >> (lane * 32));

   assign bus.fill_ready_o = (state_q == FILL);
   assign bus.busy_o       = (state_q == FILL);
   assign bus.hit_o        = hit_any;
   assign bus.miss_o       = miss;
   assign bus.fill_done_o  = done_q;
   assign bus.data_o       = hit_any ? rd_word : 32'h0;

endmodule

// File: doc/instr_cache_set_refill.md
# instr_cache_set_refill

Parameterised instruction-cache set with a multi-beat refill engine. It replaces the fixed 64-bit, single-mode set: the refill bus width is configurable, the L2 supplies data through a valid/ready handshake, the set can be flushed for `fence.i`, and a refill in progress can be aborted. One instance exists per cache index. The parent cache decodes the index into `set_active_i` and arbitrates the shared L2 fill port.

## Interface
- `B`, default 64: block size in bytes; power of 2, ≥ 8.
- `TAG_BITS`, default 20: tag width.
- `E`, default 4: associativity; power of 2, ≥ 2.
- `FILL_W`, default 64: refill beat width in bits; one of 32/64/128, and ≤ 8·B.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `set_active_i`  in  1  this set is addressed this cycle.
- `tag_i`  in  TAG_BITS  lookup tag.
- `block_i`  in  $clog2(B)  byte offset in block; bits [1:0] ignored.
- `flush_i`  in  1  invalidate all ways and abort any refill.
- `fill_valid_i`  in  1  L2 beat valid.
- `fill_data_i`  in  FILL_W  L2 beat, lowest address first.
- `fill_ready_o`  out  1  set accepts a beat.
- `hit_o`  out  1  lookup hit (combinational).
- `miss_o`  out  1  lookup miss while the set is idle (combinational).
- `busy_o`  out  1  refill in progress.
- `fill_done_o`  out  1  one-cycle pulse after a refill commits.
- `data_o`  out  32  hit word; 0 when `hit_o` is 0.

## Operation
- Derived values: BEATS = 8·B/FILL_W; WORDS = B/4. Data storage is E·BEATS entries of FILL_W bits each. The read entry index is way·BEATS + block_i[b-1:log2(FILL_W/8)]. The 32-bit lane within the entry is selected by the middle offset bits.
- Lookup happens in IDLE with `set_active_i` high:
  - A way hits when its valid bit is set and its tag equals `tag_i`.
  - `hit_o` is the OR of the per-way hits.
  - `miss_o` is `set_active_i` AND NOT `hit_o` AND (state is IDLE).
- FSM has two states, IDLE and FILL.
- IDLE → FILL when `miss_o` is high and `flush_i` is low. In that same edge:
  - Choose the victim: the lowest-index invalid way; if every way is valid, the way whose age is E-1.
  - Capture the victim, `tag_i`, and the victim's old age. The old age is taken as E-1 when the victim was invalid.
  - Clear the victim's valid bit.
  - Reset the beat counter to 0.
- In FILL: `fill_ready_o` = 1 and `busy_o` = 1; `hit_o` and `miss_o` are forced to 0.
  - Each handshake (`fill_valid_i` && `fill_ready_o`) writes the beat to entry victim·BEATS + counter, then increments the counter.
  - The last beat (counter = BEATS-1) is written and committed in the same edge: the captured tag is written, the valid bit is set, LRU is updated, and the FSM returns to IDLE.
  - `fill_done_o` is registered and asserts on the cycle after the last beat.
- LRU ages are held as $clog2(E) bits per way and form a permutation over the valid ways.
  - On a hit in IDLE: the hit way's age becomes 0. Every other valid way with age < the hit way's age increments.
  - On commit: the victim's age becomes 0. Every other valid way with age < the captured old age increments.
- `flush_i` takes priority over everything, in any state:
  - Next edge: all valid bits and ages are cleared, the FSM goes to IDLE, and the counter goes to 0.
  - A beat handshaken in the same cycle as `flush_i` is dropped, and no commit happens.
  - The parent is responsible for discarding the L2 beats still in flight after an abort.
- `tag_i`, `block_i` and `set_active_i` changing during FILL have no effect on the refill.

## Timing
- Reset values: state IDLE; all valid bits 0; all ages 0; counter 0. Outputs after reset: `fill_ready_o`, `busy_o`, `fill_done_o`, `hit_o` and `data_o` are all 0, and `miss_o` equals `set_active_i`. The data array is not reset.
- Hit latency: 0 cycles (combinational). LRU updates at the following edge.
- A miss reaches `fill_ready_o` = 1 in 1 cycle.
- Minimum refill is BEATS+1 cycles from the miss to the first hit-capable cycle.
- Reset asserted mid-FILL: the state is cleared immediately. The partial way stays invalid because its valid bit was cleared at allocation.

## Structure
- Shared package `icache_pkg` holds:
  - the `fill_state_t` enum {IDLE, FILL};
  - functions `beats(B, FILL_W)` and `lane_bits(FILL_W)`;
  - elaboration-time parameter-legality checks.
- Sub-module `icache_lru_age` implements the E-way age vector and its update rule, with inputs for hit/commit way, reference age and flush. The data array and FSM remain in the top.

## Test plan
- **Cold fills, defaults:** reset, then misses on tags 0x1..0x4 with 8 beats each → ways 0..3 filled in order; ages 3,2,1,0; `fill_done_o` pulses once per fill.
- **Eviction:** after the cold fills, hit tag 0x1, then miss tag 0x5 → way 1 (tag 0x2, age 3) is evicted; a read of offset 0x24 returns word 9 of the new data.
- **Back-pressure:** FILL_W=32, `fill_valid_i` toggling every other cycle → 16 beats accepted; `busy_o` stays high through the final beat; `fill_done_o` asserts on the cycle after the final beat.
- **Flush:** `flush_i` asserted on beat 5 of 8 → that beat is dropped; all ways invalid; the next lookup of any prior tag misses.
- **Async reset:** `reset_ni` pulsed low mid-FILL between clock edges → `fill_ready_o` and `busy_o` drop immediately; the refilled tag does not hit.
- **Width sweep:** FILL_W=128, B=32 → 2 beats; every 32-bit lane at offsets 0x00..0x1C returns the expected word.
